// File: rtl/packet_fifo_mm.sv
// Packet FIFO: bus-slave write side, packet-framed stream read side.
// A packet becomes visible to the reader only once its EOP word is committed.
module packet_fifo_mm #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 3,
  localparam int LANES     = DATA_WIDTH / 8,
  localparam int EW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [LANES-1:0]      byte_enable,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  acknowledge,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [EW-1:0]         out_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int MW = 1 + EW + DATA_WIDTH;   // stored word {eop, empty, data}
  localparam int SW = 1 + MW;                // skid entry {sop, eop, empty, data}
  localparam int RW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;

  function automatic logic [EW-1:0] empty_of(input logic [LANES-1:0] be);
    logic [EW:0] cnt;
    logic [EW:0] diff;
    cnt = '0;
    for (int i = 0; i < LANES; i++) cnt = cnt + {{EW{1'b0}}, be[i]};
    diff = (EW+1)'(LANES) - cnt;
    if (be == '0) return '0;
    else return diff[EW-1:0];
  endfunction

  logic [PW:0]           wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  open_q, open_d, ovf_q, ovf_d;
  logic [15:0]           drops_q, drops_d;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [MW-1:0]         mem_q [DEPTH];
  logic [MW-1:0]         mem_rd_q;
  logic                  pend_q, pend_d, nsop_q, nsop_d;
  logic [SW-1:0]         e0_q, e0_d, e1_q, e1_d;
  logic                  v0_q, v0_d, v1_q, v1_d;

  logic                  req_s, wr_acc_s, rd_acc_s, is_data_s, is_eop_s, is_ctrl_s;
  logic                  full_s, flush_s, mem_we_s, commit_s, fetch_s, pop_s, eop_pop_s;
  logic [PW:0]           free_s;
  logic [1:0]            occ_s;
  logic [MW-1:0]         mem_wdata_s;
  logic [RW-1:0]         status_s, reg_val_s;

  assign req_s     = (read | write) & ~ack_q;
  assign wr_acc_s  = req_s & write;
  assign rd_acc_s  = req_s & read & ~write;
  assign is_data_s = wr_acc_s && (address == ADDR_WIDTH'(0));
  assign is_eop_s  = wr_acc_s && (address == ADDR_WIDTH'(1));
  assign is_ctrl_s = wr_acc_s && (address == ADDR_WIDTH'(2));
  assign free_s    = (PW+1)'(DEPTH) - (wr_ptr_q - rd_ptr_q);
  assign full_s    = (free_s == '0);
  assign mem_wdata_s = {is_eop_s, (is_eop_s ? empty_of(byte_enable) : {EW{1'b0}}), write_data};

  // Write side: append, commit, overflow drop, abort and flush.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    open_d       = open_q;
    ovf_d        = ovf_q;
    drops_d      = drops_q;
    mem_we_s     = 1'b0;
    commit_s     = 1'b0;
    flush_s      = 1'b0;
    if (is_data_s || is_eop_s) begin
      if (ovf_q || full_s) begin
        if (is_eop_s) begin
          // the whole packet is discarded; nothing reaches the reader
          wr_ptr_d = commit_ptr_q;
          open_d   = 1'b0;
          ovf_d    = 1'b0;
          drops_d  = (drops_q == 16'hFFFF) ? drops_q : drops_q + 16'd1;
        end else begin
          open_d = 1'b1;
          ovf_d  = 1'b1;
        end
      end else begin
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (is_eop_s) begin
          commit_ptr_d = wr_ptr_q + (PW+1)'(1);
          commit_s     = 1'b1;
          open_d       = 1'b0;
        end else begin
          open_d = 1'b1;
        end
      end
    end else if (is_ctrl_s) begin
      if (write_data[1]) begin
        flush_s      = 1'b1;
        wr_ptr_d     = '0;
        commit_ptr_d = '0;
        open_d       = 1'b0;
        ovf_d        = 1'b0;
      end else if (write_data[0]) begin
        wr_ptr_d = commit_ptr_q;
        open_d   = 1'b0;
        ovf_d    = 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (write_data[2]) drops_d = 16'd0;
      else drops_d = drops_d;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Register read mux; reads see the state before this cycle's update.
  always_comb begin
    status_s        = '0;
    status_s[15:0]  = 16'(free_s);
    status_s[23:16] = (32'(pkt_cnt_q) > 32'd255) ? 8'hFF : 8'(pkt_cnt_q);
    status_s[30]    = ovf_q;
    status_s[31]    = open_q;
    reg_val_s       = '0;
    case (address)
      ADDR_WIDTH'(3): reg_val_s = status_s;
      ADDR_WIDTH'(4): reg_val_s[15:0] = drops_q;
      default:        reg_val_s = '0;
    endcase
    if (rd_acc_s) rdata_d = reg_val_s[DATA_WIDTH-1:0];
    else rdata_d = '0;
  end

  assign pop_s     = v0_q & out_ready;
  assign eop_pop_s = pop_s & e0_q[MW-1];
  assign occ_s     = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, pend_q};
  // fetch only if the word in flight is guaranteed a skid slot
  assign fetch_s   = (rd_ptr_q != commit_ptr_q) && (occ_s <= ({1'b0, pop_s} + 2'd1)) && !flush_s;

  // Reader: two-entry skid buffer fed from the 1-cycle RAM read.
  always_comb begin
    e0_d     = e0_q;
    e1_d     = e1_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    nsop_d   = nsop_q;
    pend_d   = fetch_s;
    rd_ptr_d = fetch_s ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
    if (pop_s) begin
      e0_d = e1_q;
      v0_d = v1_q;
      e1_d = '0;
      v1_d = 1'b0;
    end else begin
      e0_d = e0_d;
    end
    if (pend_q) begin
      nsop_d = mem_rd_q[MW-1];
      if (!v0_d) begin
        e0_d = {nsop_q, mem_rd_q};
        v0_d = 1'b1;
      end else begin
        e1_d = {nsop_q, mem_rd_q};
        v1_d = 1'b1;
      end
    end else begin
      nsop_d = nsop_q;
    end
    if (flush_s) begin
      e0_d     = '0;
      e1_d     = '0;
      v0_d     = 1'b0;
      v1_d     = 1'b0;
      nsop_d   = 1'b1;
      pend_d   = 1'b0;
      rd_ptr_d = '0;
    end else begin
      pend_d = pend_d;
    end
    if (flush_s) pkt_cnt_d = '0;
    else if (commit_s && !eop_pop_s) pkt_cnt_d = pkt_cnt_q + (PW+1)'(1);
    else if (!commit_s && eop_pop_s) pkt_cnt_d = pkt_cnt_q - (PW+1)'(1);
    else pkt_cnt_d = pkt_cnt_q;
  end

  // Packet RAM: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[wr_ptr_q[PW-1:0]] <= mem_wdata_s;
    if (fetch_s) mem_rd_q <= mem_q[rd_ptr_q[PW-1:0]];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      open_q       <= 1'b0;
      ovf_q        <= 1'b0;
      drops_q      <= 16'd0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      pend_q       <= 1'b0;
      nsop_q       <= 1'b1;
      e0_q         <= '0;
      e1_q         <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      open_q       <= open_d;
      ovf_q        <= ovf_d;
      drops_q      <= drops_d;
      ack_q        <= req_s;
      rdata_q      <= rdata_d;
      pend_q       <= pend_d;
      nsop_q       <= nsop_d;
      e0_q         <= e0_d;
      e1_q         <= e1_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
    end
  end

  assign acknowledge = ack_q;
  assign read_data   = rdata_q;
  assign out_valid   = v0_q;
  assign out_sop     = e0_q[MW];
  assign out_eop     = e0_q[MW-1];
  assign out_empty   = e0_q[DATA_WIDTH +: EW];
  assign out_data    = e0_q[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_packet_fifo_mm.sv
// Directed + randomized bench for packet_fifo_mm (DEPTH=8), checked against
// a queue-based packet model of committed beats, open words, flags and DROPS.
module tb_packet_fifo_mm;
  localparam int DW = 32, DEPTH = 8, AW = 3, LANES = 4, EW = 2;

  logic          clk = 1'b0;
  logic          reset, read, write, out_ready;
  logic [AW-1:0] address;
  logic [LANES-1:0] byte_enable;
  logic [DW-1:0] write_data, read_data, out_data;
  logic          acknowledge, out_valid, out_sop, out_eop;
  logic [EW-1:0] out_empty;

  packet_fifo_mm #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .address(address), .byte_enable(byte_enable),
    .read(read), .write(write), .write_data(write_data), .acknowledge(acknowledge),
    .read_data(read_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];   // committed beats not yet transferred
  beat_t open_q[$];  // stored words of the open packet
  bit    open_f, ovf_f;
  int    drops, errors, checks, rdy_mode, cyc, rx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive out_ready, score any transfer, advance to next negedge.
  task automatic step();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(out_valid), 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat", 64'({out_sop, out_eop, out_empty, out_data}), 64'(e));
        rx++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] be);
    bit    full;
    beat_t b;
    full = (DEPTH - open_q.size() - exp_q.size()) <= 0;
    if (a == 3'd0 || a == 3'd1) begin
      if (ovf_f || full) begin
        if (a == 3'd1) begin
          open_q.delete();
          drops  = (drops < 65535) ? drops + 1 : drops;
          open_f = 1'b0;
          ovf_f  = 1'b0;
        end else begin
          ovf_f  = 1'b1;
          open_f = 1'b1;
        end
      end else begin
        b.data  = d;
        b.sop   = (open_q.size() == 0);
        b.eop   = (a == 3'd1);
        b.empty = (a == 3'd1 && be != 4'h0) ? EW'(LANES - $countones(be)) : EW'(0);
        open_q.push_back(b);
        if (a == 3'd1) begin
          foreach (open_q[i]) exp_q.push_back(open_q[i]);
          open_q.delete();
          open_f = 1'b0;
        end else begin
          open_f = 1'b1;
        end
      end
    end else if (a == 3'd2) begin
      if (d[1]) begin
        open_q.delete(); exp_q.delete(); open_f = 1'b0; ovf_f = 1'b0;
      end else if (d[0]) begin
        open_q.delete(); open_f = 1'b0; ovf_f = 1'b0;
      end
      if (d[2]) drops = 0;
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] be);
    address = a; write_data = d; byte_enable = be; write = 1'b1;
    step();
    model_write(a, d, be);
    write = 1'b0;
    chk("wr_ack", 64'(acknowledge), 64'd1);
    step();
  endtask

  task automatic bus_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp, input logic [31:0] m);
    address = a; read = 1'b1;
    step();
    read = 1'b0;
    chk({tag, "_ack"}, 64'(acknowledge), 64'd1);
    chk(tag, 64'(read_data & m), 64'(exp & m));
    step();
  endtask

  function automatic logic [31:0] exp_status();
    int cnt;
    int fr;
    cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].eop) cnt++;
    fr = DEPTH - open_q.size();
    return {open_f, ovf_f, 6'd0, 8'((cnt > 255) ? 255 : cnt), 16'(fr)};
  endfunction

  // Free words are exact only once every committed beat has been streamed.
  task automatic read_status(input string tag);
    logic [31:0] e, m;
    e = exp_status();
    m = (exp_q.size() == 0) ? 32'hFFFF_FFFF : 32'hFFFF_0000;
    bus_read(tag, 3'd3, e, m);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int seen, n, len, k, rx0;
    logic [3:0] be;
    errors = 0; checks = 0; cyc = 0; rx = 0; drops = 0;
    open_f = 1'b0; ovf_f = 1'b0; rdy_mode = 1;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
    byte_enable = '0; write_data = '0; out_ready = 1'b0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_bus", 64'({acknowledge, read_data}), 64'd0);
    chk("rst_stream", 64'({out_valid, out_sop, out_eop, out_empty, out_data}), 64'd0);
    reset = 1'b0;
    step();
    read_status("rst_status");
    bus_read("rst_drops", 3'd4, 32'(drops), 32'h0000_FFFF);
    bus_read("addr5", 3'd5, 32'd0, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hDEAD_BEEF, 4'hF);

    // three-word packet and first-word latency
    rdy_mode = 0;
    bus_write(3'd0, 32'h11, 4'h0);
    bus_write(3'd0, 32'h22, 4'h0);
    bus_write(3'd1, 32'h33, 4'h3);
    chk("lat_t2", 64'(out_valid), 64'd0);
    step();
    chk("lat_t3", 64'({out_valid, out_sop, out_data}), 64'({1'b1, 1'b1, 32'h11}));
    drain("t2");
    read_status("t2_status");

    // an open packet is invisible until its EOP
    bus_write(3'd0, 32'hA0, 4'hF);
    seen = 0;
    repeat (20) begin
      seen |= int'(out_valid);
      step();
    end
    chk("t3_hold", 64'(seen), 64'd0);
    read_status("t3_open");
    bus_write(3'd1, 32'hA1, 4'h0);
    read_status("t3_closed");
    drain("t3");

    // overflow drops the whole packet; earlier packet intact
    bus_write(3'd0, 32'hB0, 4'hF);
    bus_write(3'd1, 32'hB1, 4'hF);
    drain("t4a");
    for (int i = 0; i < 8; i++) bus_write(3'd0, 32'hC0 + i, 4'($urandom_range(0, 15)));
    read_status("t4_full");
    bus_write(3'd0, 32'hCC, 4'hF);
    read_status("t4_ovf");
    bus_write(3'd1, 32'hCD, 4'hF);
    bus_read("t4_drops", 3'd4, 32'(drops), 32'h0000_FFFF);
    read_status("t4_after");

    // clear DROPS, then abort an open packet
    bus_write(3'd2, 32'h4, 4'h0);
    for (int i = 0; i < 3; i++) bus_write(3'd0, 32'hD0 + i, 4'hF);
    bus_write(3'd2, 32'h1, 4'h0);
    read_status("t5_abort");
    bus_read("t5_drops", 3'd4, 32'(drops), 32'h0000_FFFF);
    bus_write(3'd0, 32'hE0, 4'hF);
    bus_write(3'd1, 32'hE1, 4'h1);
    drain("t5");

    // backpressure 1,0,0,1 then flush mid-stream
    rdy_mode = 3;
    for (int i = 0; i < 3; i++) bus_write(3'd0, 32'hF0 + i, 4'hF);
    bus_write(3'd1, 32'hF3, 4'h7);
    drain("t6a");
    for (int i = 0; i < 3; i++) bus_write(3'd0, 32'h90 + i, 4'hF);
    bus_write(3'd1, 32'h93, 4'hF);
    n = 0;
    while (exp_q.size() > 2 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("t6_wait_timeout", 64'(exp_q.size()), 64'd2);
    bus_write(3'd2, 32'h2, 4'h0);
    chk("t6_flush_valid", 64'(out_valid), 64'd0);
    read_status("t6_flush");

    // 40 one-word packets wrap the pointers several times
    rdy_mode = 0;
    rx0 = rx;
    for (int i = 0; i < 40; i++) bus_write(3'd1, $urandom, 4'hF);
    drain("t7");
    chk("t7_count", 64'(rx - rx0), 64'd40);

    // randomized packets, random byte enables, random backpressure, occasional abort
    rdy_mode = 2;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 4);
      n = 0;
      while (exp_q.size() + len > DEPTH && n < 200) begin
        step();
        n++;
      end
      if (n >= 200) chk("t8_room_timeout", 64'(exp_q.size() + len), 64'(DEPTH));
      for (int w = 0; w < len - 1; w++) bus_write(3'd0, $urandom, 4'($urandom_range(0, 15)));
      k = $urandom_range(0, 4);
      be = (k == 0) ? 4'h0 : 4'((1 << k) - 1);
      if ($urandom_range(0, 5) == 0) bus_write(3'd2, 32'h1, 4'h0);
      else bus_write(3'd1, $urandom, be);
    end
    drain("t8");
    read_status("t8_status");

    // reset in the middle of a stalled stream
    rdy_mode = 1;
    bus_write(3'd0, 32'h51, 4'hF);
    bus_write(3'd0, 32'h52, 4'hF);
    bus_write(3'd1, 32'h53, 4'hF);
    repeat (6) step();
    chk("t9_stalled_valid", 64'({out_valid, out_sop, out_data}), 64'({1'b1, 1'b1, 32'h51}));
    reset = 1'b1;
    step();
    chk("t9_rst_stream", 64'({out_valid, out_sop, out_eop, out_empty, out_data}), 64'd0);
    chk("t9_rst_bus", 64'({acknowledge, read_data}), 64'd0);
    exp_q.delete(); open_q.delete(); open_f = 1'b0; ovf_f = 1'b0; drops = 0;
    reset = 1'b0;
    rdy_mode = 0;
    step();
    read_status("t9_status");
    bus_read("t9_drops", 3'd4, 32'(drops), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
